// File: rtl/fifo_pkg.sv
// Shared defaults and types for the modport_fifo block: 128-bit x 16-entry FIFO
// with almost-full at 14 and almost-empty at 2.
package fifo_pkg;
  localparam int DATA_WIDTH    = 128;
  localparam int DEPTH         = 16;
  localparam int ALM_FULL_LVL  = 14;
  localparam int ALM_EMPTY_LVL = 2;
  localparam int ADDR_W        = $clog2(DEPTH);

  typedef logic [DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for modport_fifo: synchronous write, registered read
// port that holds its value when no read is accepted.
module fifo_mem #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int DEPTH      = fifo_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);
  import fifo_pkg::*;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/modport_fifo.sv
// Single-clock FIFO with full/almost-full/empty/almost-empty flags decoded from a
// registered count. Define FIFO_OVF_UDF_EN to add o_overflow/o_underflow pulses.
module modport_fifo #(
  parameter int DATA_WIDTH    = fifo_pkg::DATA_WIDTH,
  parameter int DEPTH         = fifo_pkg::DEPTH,
  parameter int ALM_FULL_LVL  = fifo_pkg::ALM_FULL_LVL,
  parameter int ALM_EMPTY_LVL = fifo_pkg::ALM_EMPTY_LVL
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_wren,
  input  logic                  i_rden,
  input  logic [DATA_WIDTH-1:0] i_wrdata,
  output logic                  o_full,
  output logic                  o_alm_full,
  output logic                  o_empty,
  output logic                  o_alm_empty,
  output logic [DATA_WIDTH-1:0] o_rddata
`ifdef FIFO_OVF_UDF_EN
  ,
  output logic                  o_overflow,
  output logic                  o_underflow
`endif
);
  import fifo_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ok, rd_ok;

  assign o_full      = (count_q == CW'(DEPTH));
  assign o_alm_full  = (count_q >= CW'(ALM_FULL_LVL));
  assign o_empty     = (count_q == '0);
  assign o_alm_empty = (count_q <= CW'(ALM_EMPTY_LVL));

  // Acceptance uses the registered flags, so a full FIFO still takes a read
  // while dropping a simultaneous write, and an empty one the reverse.
  assign wr_ok = i_wren && !o_full;
  assign rd_ok = i_rden && !o_empty;

  always_comb begin
    wptr_d  = wptr_q + AW'(wr_ok);
    rptr_d  = rptr_q + AW'(rd_ok);
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_ok),
    .wr_addr (wptr_q),
    .wr_data (i_wrdata),
    .rd_en   (rd_ok),
    .rd_addr (rptr_q),
    .rd_data (o_rddata)
  );

`ifdef FIFO_OVF_UDF_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = i_wren && o_full;
    udf_d = i_rden && o_empty;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign o_overflow  = ovf_q;
  assign o_underflow = udf_q;
`endif
endmodule

// File: tb/tb_modport_fifo.sv
// Directed self-checking bench for modport_fifo; covers FIFO_OVF_UDF_EN pulses
// when that macro is defined.
module tb_modport_fifo;
  logic         clk = 1'b0;
  logic         rstn;
  logic         i_wren;
  logic         i_rden;
  logic [127:0] i_wrdata;
  logic         o_full;
  logic         o_alm_full;
  logic         o_empty;
  logic         o_alm_empty;
  logic [127:0] o_rddata;
`ifdef FIFO_OVF_UDF_EN
  logic         o_overflow;
  logic         o_underflow;
`endif

  int total = 0;
  int bad   = 0;

  modport_fifo dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_wren      (i_wren),
    .i_rden      (i_rden),
    .i_wrdata    (i_wrdata),
    .o_full      (o_full),
    .o_alm_full  (o_alm_full),
    .o_empty     (o_empty),
    .o_alm_empty (o_alm_empty),
    .o_rddata    (o_rddata)
`ifdef FIFO_OVF_UDF_EN
    ,
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
`endif
  );

  always #5 clk = ~clk;

  // One clock with the given enables; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic wr, input logic rd, input logic [127:0] d);
    i_wren   = wr;
    i_rden   = rd;
    i_wrdata = d;
    @(posedge clk);
    #1;
    i_wren = 1'b0;
    i_rden = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] flags;
    rstn = 1'b0; i_wren = 1'b0; i_rden = 1'b0; i_wrdata = '0;
    repeat (3) @(posedge clk);
    #1;
    flags = {o_empty, o_alm_empty, o_full, o_alm_full};
    total++;
    if (flags !== 4'b1100) begin
      $display("FAIL reset_flags_held got=%b want=1100", flags); bad++;
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    flags = {o_empty, o_alm_empty, o_full, o_alm_full};
    total++;
    if (flags !== 4'b1100 || o_rddata !== 128'h0) begin
      $display("FAIL reset_release got flags=%b data=%h want flags=1100 data=0", flags, o_rddata); bad++;
    end
    $display("reset: flags=%b rddata=%h", flags, o_rddata);
  endtask

  task automatic test_fill();
    logic [3:0] flags, want;
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 128'(i));
      flags = {o_empty, o_alm_empty, o_full, o_alm_full};
      want  = {1'b0, (i <= 2) ? 1'b1 : 1'b0, (i == 16) ? 1'b1 : 1'b0, (i >= 14) ? 1'b1 : 1'b0};
      total++;
      if (flags !== want) begin
        $display("FAIL fill_flags write=%0d got=%b want=%b", i, flags, want); bad++;
      end
      $display("fill: write %0d data=%h flags=%b", i, i, flags);
    end
    cyc(1'b1, 1'b0, 128'hDEAD);
    total++;
    if (o_full !== 1'b1 || o_alm_full !== 1'b1) begin
      $display("FAIL fill_drop_17th got full=%b alm_full=%b want 1 1", o_full, o_alm_full); bad++;
    end
    $display("fill: write 17 data=dead dropped full=%b", o_full);
  endtask

  task automatic test_drain();
    logic [3:0] flags, want;
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0, 1'b1, '0);
      flags = {o_empty, o_alm_empty, o_full, o_alm_full};
      want  = {(k == 16) ? 1'b1 : 1'b0, (k >= 14) ? 1'b1 : 1'b0, 1'b0, (k <= 2) ? 1'b1 : 1'b0};
      total++;
      if (o_rddata !== 128'(k) || flags !== want) begin
        $display("FAIL drain_read k=%0d got data=%h flags=%b want data=%h flags=%b",
                 k, o_rddata, flags, 128'(k), want); bad++;
      end
      $display("drain: read %0d data=%h flags=%b", k, o_rddata, flags);
    end
    cyc(1'b0, 1'b1, '0);
    total++;
    if (o_rddata !== 128'h10 || o_empty !== 1'b1) begin
      $display("FAIL drain_empty_read got data=%h empty=%b want data=10 empty=1", o_rddata, o_empty); bad++;
    end
    $display("drain: read while empty data=%h", o_rddata);
  endtask

  task automatic test_wrap();
    logic [127:0] d;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 10; i++) begin
        cyc(1'b1, 1'b0, 128'h100 * (pass + 1) + 128'(i));
      end
      for (int i = 0; i < 10; i++) begin
        cyc(1'b0, 1'b1, '0);
        d = 128'h100 * (pass + 1) + 128'(i);
        total++;
        if (o_rddata !== d) begin
          $display("FAIL wrap_order pass=%0d i=%0d got=%h want=%h", pass, i, o_rddata, d); bad++;
        end
        $display("wrap: pass %0d read %0d data=%h", pass, i, o_rddata);
      end
      total++;
      if (o_empty !== 1'b1 || o_alm_empty !== 1'b1) begin
        $display("FAIL wrap_empty pass=%0d got empty=%b alm_empty=%b want 1 1", pass, o_empty, o_alm_empty); bad++;
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [127:0] exp_q [$];
    logic [127:0] d;
    logic [3:0]   flags;
    // Mid-level: count 5, four read+write cycles keep it at 5.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 128'hA0 + 128'(i));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 128'hB0 + 128'(i));
      flags = {o_empty, o_alm_empty, o_full, o_alm_full};
      total++;
      if (o_rddata !== 128'hA0 + 128'(i) || flags !== 4'b0000) begin
        $display("FAIL simul_mid i=%0d got data=%h flags=%b want data=%h flags=0000",
                 i, o_rddata, flags, 128'hA0 + 128'(i)); bad++;
      end
      $display("simul: mid cycle %0d data=%h flags=%b", i, o_rddata, flags);
    end
    exp_q = '{128'hA4, 128'hB0, 128'hB1, 128'hB2, 128'hB3};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, '0);
      d = exp_q[i];
      total++;
      if (o_rddata !== d || o_empty !== ((i == 4) ? 1'b1 : 1'b0)) begin
        $display("FAIL simul_mid_drain i=%0d got data=%h empty=%b want data=%h", i, o_rddata, o_empty, d); bad++;
      end
    end
    // Full: first cycle reads only (write dropped), then both accepted.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 128'hF00 + 128'(i));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 128'hC00 + 128'(i));
      total++;
      if (o_rddata !== 128'hF00 + 128'(i) || o_full !== 1'b0 || o_alm_full !== 1'b1) begin
        $display("FAIL simul_full i=%0d got data=%h full=%b alm_full=%b want data=%h full=0 alm_full=1",
                 i, o_rddata, o_full, o_alm_full, 128'hF00 + 128'(i)); bad++;
      end
      $display("simul: full cycle %0d data=%h full=%b", i, o_rddata, o_full);
    end
    exp_q.delete();
    for (int i = 4; i < 16; i++) exp_q.push_back(128'hF00 + 128'(i));
    for (int i = 1; i < 4; i++) exp_q.push_back(128'hC00 + 128'(i));
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 1'b1, '0);
      d = exp_q[i];
      total++;
      if (o_rddata !== d || o_empty !== ((i == 14) ? 1'b1 : 1'b0)) begin
        $display("FAIL simul_full_drain i=%0d got data=%h empty=%b want data=%h", i, o_rddata, o_empty, d); bad++;
      end
    end
    $display("simul: full drain done empty=%b", o_empty);
  endtask

`ifdef FIFO_OVF_UDF_EN
  task automatic test_ovf_udf();
    cyc(1'b0, 1'b1, '0);
    total++;
    if (o_underflow !== 1'b1) begin
      $display("FAIL udf_pulse got=%b want=1", o_underflow); bad++;
    end
    cyc(1'b0, 1'b0, '0);
    total++;
    if (o_underflow !== 1'b0) begin
      $display("FAIL udf_clear got=%b want=0", o_underflow); bad++;
    end
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 128'(i));
    total++;
    if (o_overflow !== 1'b0) begin
      $display("FAIL ovf_idle got=%b want=0", o_overflow); bad++;
    end
    cyc(1'b1, 1'b0, 128'hBAD);
    total++;
    if (o_overflow !== 1'b1) begin
      $display("FAIL ovf_pulse got=%b want=1", o_overflow); bad++;
    end
    cyc(1'b0, 1'b0, '0);
    total++;
    if (o_overflow !== 1'b0) begin
      $display("FAIL ovf_clear got=%b want=0", o_overflow); bad++;
    end
    $display("ovf_udf: pulses checked");
  endtask
`endif

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 128'h77 + 128'(i));
    cyc(1'b0, 1'b1, '0);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (o_empty !== 1'b1 || o_alm_empty !== 1'b1 || o_rddata !== 128'h0) begin
      $display("FAIL mid_reset got empty=%b alm_empty=%b data=%h want 1 1 0", o_empty, o_alm_empty, o_rddata); bad++;
    end
    $display("mid_reset: empty=%b data=%h", o_empty, o_rddata);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
`ifdef FIFO_OVF_UDF_EN
    test_ovf_udf();
`endif
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/modport_fifo.md
Name: modport_fifo

Overview:
- Synchronous single-clock FIFO, 128-bit data path, with full, almost-full, empty and almost-empty status flags.
- Sits between a producer and a consumer that both drive it on the rising edge of `clk`.
- Write and read are simple level enables sampled each clock; there is no ready/valid back-pressure beyond the status flags.

Parameters:
- DATA_WIDTH, 128, width of `i_wrdata` and `o_rddata`.
- DEPTH, 16, number of entries; must be a power of two and at least 4.
- ALM_FULL_LVL, 14, `o_alm_full` is asserted when the occupancy count is at least this value.
- ALM_EMPTY_LVL, 2, `o_alm_empty` is asserted when the occupancy count is at most this value.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rstn  input  1  asynchronous, active-low reset.
- i_wren  input  1  write request.
- i_rden  input  1  read request.
- i_wrdata  input  DATA_WIDTH  write data.
- o_full  output  1  count == DEPTH.
- o_alm_full  output  1  count >= ALM_FULL_LVL.
- o_empty  output  1  count == 0.
- o_alm_empty  output  1  count <= ALM_EMPTY_LVL.
- o_rddata  output  DATA_WIDTH  registered read data.

Behaviour:
- State: write pointer `wptr` and read pointer `rptr`, each log2(DEPTH) bits and wrapping naturally; occupancy `count`, log2(DEPTH)+1 bits; storage array of DEPTH×DATA_WIDTH; `o_rddata` register.
- Reset (`rstn`=0, asynchronous): wptr=0, rptr=0, count=0, o_rddata=0.
  - Flags during reset: o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0.
  - Storage contents are not reset.
- Write acceptance: `wr_ok = i_wren && !o_full`.
  - When accepted: `mem[wptr] <= i_wrdata`, then `wptr` increments.
  - A write while full is dropped; no state changes.
- Read acceptance: `rd_ok = i_rden && !o_empty`.
  - When accepted: `o_rddata <= mem[rptr]` on the same edge, then `rptr` increments.
  - Data is therefore visible one clock after the edge that samples `i_rden`.
  - A read while empty is dropped and `o_rddata` holds its previous value.
- Count update: +1 on write only, −1 on read only, unchanged when both or neither are accepted.
- Simultaneous read and write:
  - Full: the read is accepted and the write is dropped, because the full check uses the current count. Count goes from DEPTH to DEPTH−1.
  - Empty: the write is accepted and the read is dropped. Count goes from 0 to 1; there is no write-to-read bypass.
  - Otherwise: both are accepted and count is unchanged.
- Flags are pure decodes of the registered `count`, so they update in the cycle after the causing edge. No combinational path runs from the inputs to any output.
- Pointer wrap-around from DEPTH−1 to 0 is seamless; ordering is strict first-in, first-out.
- Reset asserted mid-operation: all contents are lost and the FIFO reports empty immediately.

Optional Feature:
- Macro: `FIFO_OVF_UDF_EN`.
- Defined: adds two 1-bit outputs.
  - `o_overflow` is registered, reset 0, and pulses high for one cycle after the edge where `i_wren && o_full`.
  - `o_underflow` is registered, reset 0, and pulses high for one cycle after the edge where `i_rden && o_empty`.
- Undefined: those ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package `fifo_pkg` holds the defaults for DATA_WIDTH, DEPTH, ALM_FULL_LVL and ALM_EMPTY_LVL, plus `typedef logic [DATA_WIDTH-1:0] data_t` and the derived `ADDR_W = $clog2(DEPTH)`.
- One sub-module, `fifo_mem`, holds the storage: simple dual-port, synchronous write, registered read output. The top level owns the pointers, the count and the flags.

Test Plan:
- Reset: hold rstn=0, then release → o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0.
- Fill: write 16 words 0x1..0x10 →
  - o_alm_empty deasserts after the 3rd write;
  - o_alm_full asserts after the 14th write;
  - o_full asserts after the 16th write;
  - a 17th write of 0xDEAD is dropped.
- Drain: issue 16 reads → o_rddata returns 0x1..0x10 in order, each one cycle after its read; then o_empty=1, and a further read leaves o_rddata=0x10.
- Wrap: write 10, read 10, write 10, read 10 with distinct data → order is preserved across the pointer wrap and count returns to 0.
- Simultaneous: at count=5, assert i_wren and i_rden together for 4 cycles → count stays 5 and the flags are unchanged. When full, the same stimulus → count becomes 15 and the write is dropped.
- With FIFO_OVF_UDF_EN: a read while empty → o_underflow pulses for one cycle; a write while full → o_overflow pulses for one cycle.
